// File: rtl/led_pwm_pkg.sv
// ============================================================================
// Module      : led_pwm_pkg
// Description : Shared mode encodings and elaboration-time helpers for the
//               PWM LED chaser.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pwm_pkg;

    localparam logic MODE_ROTATE   = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;

    // Power-on duty profile: each channel is a quarter of its lower neighbour.
    function automatic logic [31:0] default_duty(input int i, input int duty_w);
        logic [31:0] full;
        full = (32'd1 << duty_w) - 32'd1;
        return (2 * i >= 32) ? 32'd0 : (full >> (2 * i));
    endfunction

    function automatic int calc_presc(input int clk_hz, input int pwm_hz, input int duty_w);
        longint q;
        if (pwm_hz <= 0) begin
            q = longint'(clk_hz);
        end else begin
            q = longint'(clk_hz) / (longint'(pwm_hz) << duty_w);
        end
        return (q < 1) ? 1 : int'(q);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_chaser_chan.sv
// ============================================================================
// Module      : pwm_chan
// Description : One PWM channel: frame-aligned active duty register,
//               comparator against the shared counter, registered output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_chan #(
    parameter int                DUTY_W     = 8,
    parameter logic [DUTY_W-1:0] RESET_DUTY = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty_shadow,
    input  logic              load_en,
    output logic              pwm_out
);

    logic [DUTY_W-1:0] active_q, active_d;
    logic              pwm_q, pwm_d;

    always_comb begin
        active_d = load_en ? duty_shadow : active_q;
        pwm_d    = (cnt < active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= RESET_DUTY;
            pwm_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

`default_nettype wire

// File: rtl/led_pwm_chaser.sv
// ============================================================================
// Module      : led_pwm_chaser
// Description : N-channel PWM LED chaser with shared timebase, rotate or
//               ping-pong pattern stepper and runtime per-channel duty writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pwm_chaser
    import led_pwm_pkg::*;
#(
    parameter int CLK_HZ      = 27_000_000,
    parameter int PWM_HZ      = 1024,
    parameter int N_CH        = 8,
    parameter int DUTY_W      = 8,
    parameter int STEP_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    mode,
    input  logic                    load,
    input  logic [$clog2(N_CH)-1:0] load_ch,
    input  logic [DUTY_W-1:0]       load_duty,
    output logic [N_CH-1:0]         led,
    output logic                    step_pulse,
    output logic [$clog2(N_CH)-1:0] head_pos
);

    localparam int C_CH_W    = $clog2(N_CH);
    localparam int C_PRESC   = calc_presc(CLK_HZ, PWM_HZ, DUTY_W);
    localparam int C_PRESC_W = (C_PRESC > 1) ? $clog2(C_PRESC) : 1;
    localparam int C_FC_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    typedef logic [N_CH-1:0][DUTY_W-1:0] duty_arr_t;

    function automatic duty_arr_t reset_profile();
        duty_arr_t p;
        for (int i = 0; i < N_CH; i++) begin
            p[i] = DUTY_W'(default_duty(i, DUTY_W));
        end
        return p;
    endfunction

    localparam duty_arr_t C_SHADOW_RST = reset_profile();

    logic [C_PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [C_FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic [C_CH_W-1:0]    head_q, head_d;
    logic                 pp_dir_q, pp_dir_d;
    logic                 mode_q;
    logic                 step_q;
    duty_arr_t            shadow_q, shadow_d;

    logic                 w_tick, w_frame_end, w_step, w_d, w_mode_rise, w_load_ok;
    logic [C_CH_W-1:0]    w_head_up, w_head_dn;

    // Shared timebase
    always_comb begin
        w_tick      = (presc_q == C_PRESC_W'(C_PRESC - 1));
        presc_d     = w_tick ? '0 : presc_q + C_PRESC_W'(1);
        pwm_cnt_d   = w_tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        w_frame_end = w_tick && (pwm_cnt_q == '1);
    end

    always_comb begin
        w_step      = w_frame_end && en && (frame_cnt_q == C_FC_W'(STEP_FRAMES - 1));
        frame_cnt_d = frame_cnt_q;
        if (w_frame_end && en) begin
            frame_cnt_d = w_step ? '0 : frame_cnt_q + C_FC_W'(1);
        end
    end

    // Entering ping-pong takes its starting direction from dir on that same cycle.
    always_comb begin
        w_mode_rise = (mode == MODE_PINGPONG) && (mode_q == MODE_ROTATE);
        w_d         = (mode == MODE_PINGPONG) ? (w_mode_rise ? dir : pp_dir_q) : dir;
        w_head_up   = (head_q == C_CH_W'(N_CH - 1)) ? '0 : head_q + C_CH_W'(1);
        w_head_dn   = (head_q == '0) ? C_CH_W'(N_CH - 1) : head_q - C_CH_W'(1);
        head_d      = head_q;
        pp_dir_d    = w_mode_rise ? dir : pp_dir_q;
        if (w_step) begin
            head_d = w_d ? w_head_dn : w_head_up;
            if ((mode == MODE_PINGPONG) &&
                ((!w_d && (w_head_up == C_CH_W'(N_CH - 1))) || (w_d && (w_head_dn == '0)))) begin
                pp_dir_d = ~w_d;
            end
        end
    end

    // Rotation first, then the write lands on the post-rotation index.
    always_comb begin
        w_load_ok = ({1'b0, load_ch} < (C_CH_W + 1)'(N_CH));
        shadow_d  = shadow_q;
        if (w_step) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_d[i] = w_d ? shadow_q[(i + 1) % N_CH] : shadow_q[(i + N_CH - 1) % N_CH];
            end
        end
        if (load && w_load_ok) begin
            shadow_d[load_ch] = load_duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            frame_cnt_q <= '0;
            head_q      <= '0;
            pp_dir_q    <= 1'b0;
            mode_q      <= MODE_ROTATE;
            step_q      <= 1'b0;
            shadow_q    <= C_SHADOW_RST;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            head_q      <= head_d;
            pp_dir_q    <= pp_dir_d;
            mode_q      <= mode;
            step_q      <= w_step;
            shadow_q    <= shadow_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        pwm_chan #(
            .DUTY_W     (DUTY_W),
            .RESET_DUTY (C_SHADOW_RST[g])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .cnt         (pwm_cnt_q),
            .duty_shadow (shadow_d[g]),
            .load_en     (w_frame_end),
            .pwm_out     (led[g])
        );
    end

    assign step_pulse = step_q;
    assign head_pos   = head_q;

endmodule

`default_nettype wire
